psum_drain: RTL

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_drain.sv | 100 ++++++++++
 1 files changed

// File: rtl/psum_drain.sv
// Drains FIFO_DEPTH accumulated psum rows, quantizes each lane and writes rows to GLB.
// Define PSUM_DRAIN_RELU_EN to clamp negative lanes to zero before saturation.
module psum_drain #(
    parameter int PE_SIZE    = 16,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [4:0]                    shift_i,
    output logic [PE_SIZE-1:0]            rden_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] psum_row_i,
    output logic                          glb_wren_o,
    input  logic                          glb_ready_i,
    output logic [ADDR_WIDTH-1:0]         glb_addr_o,
    output logic [OUT_WIDTH*PE_SIZE-1:0]  glb_wdata_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int CW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic signed [DATA_WIDTH-1:0] QMAX = DATA_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_WIDTH-1:0] QMIN = -DATA_WIDTH'(2 ** (OUT_WIDTH - 1));
    localparam logic [CW-1:0] LAST = CW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q;
    logic [ADDR_WIDTH-1:0]          base_q;
    logic [4:0]                     shift_q;
    logic [OUT_WIDTH*PE_SIZE-1:0]   wdata_q;
    logic [OUT_WIDTH*PE_SIZE-1:0]   q_row;

    function automatic logic [OUT_WIDTH-1:0] quant(
        input logic signed [DATA_WIDTH-1:0] p,
        input logic [4:0]                   sh
    );
        logic signed [DATA_WIDTH-1:0] s;
        s = p >>> sh;
`ifdef PSUM_DRAIN_RELU_EN
        if (s < 0) s = '0;
`endif
        if (s > QMAX) s = QMAX;
        else if (s < QMIN) s = QMIN;
        return s[OUT_WIDTH-1:0];
    endfunction

    always_comb begin
        q_row = '0;
        for (int j = 0; j < PE_SIZE; j++) begin
            q_row[OUT_WIDTH*(PE_SIZE-j)-1 -: OUT_WIDTH] =
                quant(psum_row_i[DATA_WIDTH*(PE_SIZE-j)-1 -: DATA_WIDTH], shift_q);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_i) state_d = READ;
            READ:  state_d = CAPT;
            CAPT:  state_d = WRITE;
            WRITE: if (glb_ready_i) state_d = (cnt_q == LAST) ? DONE : READ;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            shift_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                base_q  <= base_addr_i;
                shift_q <= shift_i;
                cnt_q   <= '0;
            end
            if (state_q == CAPT) wdata_q <= q_row;
            // Counter advances only on a completed handshake of a non-final row
            if (state_q == WRITE && glb_ready_i && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rden_o      = {PE_SIZE{state_q == READ}};
    assign glb_wren_o  = (state_q == WRITE);
    assign glb_addr_o  = base_q + ADDR_WIDTH'(cnt_q);
    assign glb_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule
